// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared widths and the round-robin pick helper for adder_share_arb.
package adder_share_pkg;
   localparam int DATA_W = 32;
   localparam int SUM_W = 33;
   localparam int MAX_REQ = 16;
   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } pick_t;
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [3:0] ptr, input int n);
      pick_t p;
      int j;
      p = '0;
      for (int k = 0; k < MAX_REQ; k++) begin
         j = (int'(ptr) + k) % n;
         if (k < n && !p.found && valid[j[3:0]]) begin
            p.found = 1'b1;
            p.idx = j[3:0];
         end
      end
      return p;
   endfunction
endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select; owns the rotating pointer.
module rr_arbiter import adder_share_pkg::*; #(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid_i,
   input  logic            can_issue_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] win_id_o
);
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   pick_t pick;
   logic accept;
   always_comb begin
      pick = rr_pick(MAX_REQ'(req_valid_i), 4'(rr_ptr_q), NREQ);
      win_id_o = ID_W'(pick.idx);
      accept = pick.found & can_issue_i & ~rst;
      grant_o = accept ? NREQ'(1) << win_id_o : '0;
      rr_ptr_d = (win_id_o == ID_W'(NREQ - 1)) ? '0 : win_id_o + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else if (accept) rr_ptr_q <= rr_ptr_d;
   end
endmodule

// File: rtl/csa32.sv
// csa32: 32-bit carry-skip adder, eight 4-bit ripple blocks with propagate bypass.
module csa32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);
   logic c, r;
   always_comb begin
      c = cin_i;
      r = 1'b0;
      sum_o = '0;
      for (int k = 0; k < 8; k++) begin
         r = c;
         for (int j = 4 * k; j < 4 * k + 4; j++) begin
            sum_o[j] = a_i[j] ^ b_i[j] ^ r;
            r = (a_i[j] & b_i[j]) | (r & (a_i[j] ^ b_i[j]));
         end
         c = &(a_i[4*k +: 4] ^ b_i[4*k +: 4]) ? c : r;
      end
      cout_o = c;
   end
endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin time-sharing of one csa32 adder among NREQ requesters.
// Define ADDER_SHARE_ARB_SUB_EN to add per-requester subtract (req_sub / resp_is_sub).
module adder_share_arb import adder_share_pkg::*; #(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_a,
   input  logic [NREQ*DATA_W-1:0] req_b,
   input  logic [NREQ-1:0]        req_cin,
`ifdef ADDER_SHARE_ARB_SUB_EN
   input  logic [NREQ-1:0]        req_sub,
   output logic                   resp_is_sub,
`endif
   output logic [NREQ-1:0]        req_ready,
   output logic                   resp_valid,
   output logic [SUM_W-1:0]       resp_sum,
   output logic [ID_W-1:0]        resp_id,
   input  logic                   resp_ready
);
   logic resp_valid_q, resp_valid_d;
   logic [SUM_W-1:0] resp_sum_q, resp_sum_d;
   logic [ID_W-1:0] resp_id_q, resp_id_d, win;
   logic can_issue, accept, cin_eff, add_cout;
   logic [DATA_W-1:0] a_mux, b_eff, add_sum;
   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .can_issue_i(can_issue),
      .grant_o(req_ready), .win_id_o(win)
   );
   assign a_mux = req_a[DATA_W*win +: DATA_W];
`ifdef ADDER_SHARE_ARB_SUB_EN
   logic resp_is_sub_q;
   // Subtract is A + ~B + 1; carry-out then reads as the no-borrow flag.
   assign b_eff = req_sub[win] ? ~req_b[DATA_W*win +: DATA_W] : req_b[DATA_W*win +: DATA_W];
   assign cin_eff = req_sub[win] | req_cin[win];
   always_ff @(posedge clk) begin
      if (rst) resp_is_sub_q <= 1'b0;
      else if (accept) resp_is_sub_q <= req_sub[win];
   end
   assign resp_is_sub = resp_is_sub_q;
`else
   assign b_eff = req_b[DATA_W*win +: DATA_W];
   assign cin_eff = req_cin[win];
`endif
   csa32 u_add (.a_i(a_mux), .b_i(b_eff), .cin_i(cin_eff), .sum_o(add_sum), .cout_o(add_cout));
   always_comb begin
      can_issue = ~resp_valid_q | resp_ready;
      accept = |req_ready;
      resp_valid_d = accept | (resp_valid_q & ~resp_ready);
      resp_sum_d = accept ? {add_cout, add_sum} : resp_sum_q;
      resp_id_d = accept ? win : resp_id_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_sum_q <= '0;
         resp_id_q <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_sum_q <= resp_sum_d;
         resp_id_q <= resp_id_d;
      end
   end
   assign resp_valid = resp_valid_q;
   assign resp_sum = resp_sum_q;
   assign resp_id = resp_id_q;
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: scoreboard bench for adder_share_arb (4 requesters).
module tb_adder_share_arb;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] req_valid, req_cin, req_ready;
   logic [127:0] req_a, req_b;
   logic resp_valid, resp_ready;
   logic [32:0] resp_sum;
   logic [1:0] resp_id;
`ifdef ADDER_SHARE_ARB_SUB_EN
   logic [3:0] req_sub;
   logic resp_is_sub;
`endif
   typedef struct {
      logic [1:0]  id;
      logic [32:0] sum;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   adder_share_arb #(.NREQ(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_cin(req_cin),
`ifdef ADDER_SHARE_ARB_SUB_EN
      .req_sub(req_sub), .resp_is_sub(resp_is_sub),
`endif
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_sum(resp_sum),
      .resp_id(resp_id), .resp_ready(resp_ready)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_cin[i] = c;
   endtask
   task automatic push(input int i);
      exp_t x;
      logic [31:0] a, b;
      a = req_a[32*i +: 32];
      b = req_b[32*i +: 32];
      x.id = 2'(i);
      x.sum = {1'b0, a} + {1'b0, b} + {32'd0, req_cin[i]};
`ifdef ADDER_SHARE_ARB_SUB_EN
      if (req_sub[i]) x.sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
`endif
      q.push_back(x);
   endtask
   task automatic test_reset;
      rst = 1'b1;
      req_valid = 4'b0000;
      resp_ready = 1'b0;
      tick();
      tick();
      total++;
      if (resp_valid !== 1'b0 || resp_sum !== 33'd0 || resp_id !== 2'd0) begin
         bad++;
         $display("FAIL reset_state: got v=%b sum=%h id=%0d want v=0 sum=0 id=0", resp_valid, resp_sum, resp_id);
      end
      req_valid = 4'b1111;
      #1;
      total++;
      if (req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      req_valid = 4'b0000;
      rst = 1'b0;
      tick();
   endtask
   task automatic test_carry;
      logic [32:0] held;
      set_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
      req_valid = 4'b0001;
      resp_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL carry_ready: got %b want 0001", req_ready);
      end
      push(0);
      tick();
      req_valid = 4'b0000;
      e = q.pop_front();
      total++;
      if (resp_valid !== 1'b1 || resp_id !== e.id || resp_sum !== e.sum || resp_sum !== 33'h1_0000_0000) begin
         bad++;
         $display("FAIL carry_sum: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", resp_valid, resp_id, resp_sum, e.id, e.sum);
      end
      held = resp_sum;
      tick();
      total++;
      if (resp_valid !== 1'b0 || resp_sum !== held || resp_id !== 2'd0) begin
         bad++;
         $display("FAIL drain_hold: got v=%b sum=%h id=%0d want v=0 sum=%h id=0", resp_valid, resp_sum, resp_id, held);
      end
   endtask
   task automatic test_round_robin;
      logic [3:0] exp_rdy;
      int w;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         w = k % 4;
         exp_rdy = 4'b0001 << w;
         #1;
         total++;
         if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL rr_ready%0d: got %b want %b", k, req_ready, exp_rdy);
         end
         push(w);
         tick();
         e = q.pop_front();
         total++;
         if (resp_valid !== 1'b1 || resp_id !== e.id || resp_sum !== e.sum) begin
            bad++;
            $display("FAIL rr_resp%0d: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", k, resp_valid, resp_id, resp_sum, e.id, e.sum);
         end
         set_op(w, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      req_valid = 4'b0000;
      tick();
      total++;
      if (resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL rr_drain: got v=%b want 0", resp_valid);
      end
   endtask
   task automatic test_stall;
      logic [32:0] held;
      set_op(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
      set_op(2, 32'h8000_0000, 32'h8000_0001, 1'b0);
      req_valid = 4'b0001;
      resp_ready = 1'b1;
      push(0);
      tick();
      held = resp_sum;
      resp_ready = 1'b0;
      req_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== held) begin
            bad++;
            $display("FAIL stall%0d: got rdy=%b v=%b id=%0d sum=%h want rdy=0000 v=1 id=0 sum=%h", k, req_ready, resp_valid, resp_id, resp_sum, held);
         end
         tick();
      end
      resp_ready = 1'b1;
      #1;
      e = q.pop_front();
      total++;
      if (req_ready !== 4'b0100 || resp_id !== e.id || resp_sum !== e.sum) begin
         bad++;
         $display("FAIL stall_release: got rdy=%b id=%0d sum=%h want rdy=0100 id=%0d sum=%h", req_ready, resp_id, resp_sum, e.id, e.sum);
      end
      push(2);
      tick();
      req_valid = 4'b0000;
      e = q.pop_front();
      total++;
      if (resp_valid !== 1'b1 || resp_id !== e.id || resp_sum !== e.sum) begin
         bad++;
         $display("FAIL stall_result: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", resp_valid, resp_id, resp_sum, e.id, e.sum);
      end
      tick();
   endtask
   task automatic test_wrap;
      set_op(1, 32'd100, 32'd23, 1'b0);
      req_valid = 4'b0010;
      push(1);
      tick();
      e = q.pop_front();
      total++;
      if (resp_id !== e.id || resp_sum !== e.sum) begin
         bad++;
         $display("FAIL wrap_setup: got id=%0d sum=%h want id=%0d sum=%h", resp_id, resp_sum, e.id, e.sum);
      end
      set_op(1, 32'd5, 32'd7, 1'b1);
      set_op(3, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
      req_valid = 4'b1010;
      #1;
      total++;
      if (req_ready !== 4'b1000) begin
         bad++;
         $display("FAIL wrap_first: got %b want 1000", req_ready);
      end
      push(3);
      tick();
      e = q.pop_front();
      total++;
      if (resp_valid !== 1'b1 || resp_id !== e.id || resp_sum !== e.sum) begin
         bad++;
         $display("FAIL wrap_r3: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", resp_valid, resp_id, resp_sum, e.id, e.sum);
      end
      req_valid = 4'b0010;
      push(1);
      tick();
      req_valid = 4'b0000;
      e = q.pop_front();
      total++;
      if (resp_id !== e.id || resp_sum !== e.sum || resp_sum !== 33'd13) begin
         bad++;
         $display("FAIL wrap_r1: got id=%0d sum=%h want id=%0d sum=%h", resp_id, resp_sum, e.id, e.sum);
      end
      tick();
   endtask
   task automatic test_reset_mid;
      set_op(2, 32'd9, 32'd9, 1'b0);
      req_valid = 4'b0100;
      resp_ready = 1'b0;
      tick();
      total++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin
         bad++;
         $display("FAIL mid_load: got v=%b id=%0d want v=1 id=2", resp_valid, resp_id);
      end
      rst = 1'b1;
      req_valid = 4'b0000;
      tick();
      rst = 1'b0;
      total++;
      if (resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_flush: got v=%b want 0", resp_valid);
      end
      for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin
         bad++;
         $display("FAIL mid_ptr: got %b want 0001", req_ready);
      end
      push(0);
      tick();
      req_valid = 4'b0000;
      e = q.pop_front();
      total++;
      if (resp_valid !== 1'b1 || resp_id !== e.id || resp_sum !== e.sum) begin
         bad++;
         $display("FAIL mid_resp: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", resp_valid, resp_id, resp_sum, e.id, e.sum);
      end
      tick();
   endtask
`ifdef ADDER_SHARE_ARB_SUB_EN
   task automatic test_sub;
      set_op(1, 32'd3, 32'd5, 1'b0);
      req_sub = 4'b0010;
      req_valid = 4'b0010;
      resp_ready = 1'b1;
      push(1);
      tick();
      req_valid = 4'b0000;
      e = q.pop_front();
      total++;
      if (resp_sum !== e.sum || resp_sum !== 33'h0_FFFF_FFFE || resp_is_sub !== 1'b1) begin
         bad++;
         $display("FAIL sub: got sum=%h sub=%b want sum=%h sub=1", resp_sum, resp_is_sub, e.sum);
      end
      req_sub = 4'b0000;
      tick();
   endtask
`endif
   initial begin
      req_a = '0;
      req_b = '0;
      req_cin = '0;
`ifdef ADDER_SHARE_ARB_SUB_EN
      req_sub = '0;
`endif
      test_reset();
      test_carry();
      test_round_robin();
      test_stall();
      test_wrap();
      test_reset_mid();
`ifdef ADDER_SHARE_ARB_SUB_EN
      test_sub();
`endif
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_empty: got %0d left want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Time-shares one 32-bit carry-skip adder datapath among NREQ independent requesters.
- Round-robin arbitration selects one requester per cycle. Its operands drive the adder, and the 33-bit result is captured in a response register tagged with the requester ID.
- Sits between client blocks that need occasional 32-bit adds and the single adder instance, so the adder is not replicated per client.

Parameters:
- NREQ, 4, number of requesters (2..16)
- ID_W, $clog2(NREQ), width of requester ID

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*32  operand A, requester i at [32*i+31:32*i]
- req_b  in  NREQ*32  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- resp_valid  out  1  response register holds a result
- resp_sum  out  33  {carry_out, sum[31:0]}
- resp_id  out  ID_W  index of the requester that produced resp_sum
- resp_ready  in  1  consumer accepts the response

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - resp_valid=0, resp_sum=0, resp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst is high.
- Slot availability: can_issue = ~resp_valid | resp_ready.
- Arbitration:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward with wrap at NREQ-1 -> 0.
  - req_ready[winner] = can_issue. All other req_ready bits are 0.
  - req_ready must not depend on resp_sum; it may depend on req_valid.
- Transfer: occurs when req_valid[i] & req_ready[i]. On that edge:
  - resp_sum <= req_a[i] + req_b[i] + req_cin[i], as a 33-bit zero-extended sum; bit 32 is carry-out.
  - resp_id <= i, resp_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- Drain only (resp_valid & resp_ready, no transfer): resp_valid <= 0; resp_sum and resp_id hold their last values.
- Simultaneous drain and transfer: the new result is loaded and resp_valid stays 1. Throughput is 1 add per cycle.
- Stall (resp_valid & ~resp_ready):
  - All req_ready=0; resp_sum and resp_id stable; rr_ptr unchanged.
  - Requesters must hold valid and operands until accepted; the block does not buffer them.
- Latency: 1 cycle from accept to resp_valid.
- No request pending: rr_ptr unchanged, no state change except drain.
- Reset mid-operation: a pending response is discarded (resp_valid=0) and rr_ptr returns to 0 on the next edge.
- Fairness: a continuously asserting requester waits at most NREQ-1 accepted transfers.

Optional Feature:
- Macro ADDER_SHARE_ARB_SUB_EN.
- Defined:
  - Adds input port req_sub [NREQ].
  - When req_sub[i]=1, the add uses ~req_b[i] with carry-in forced to 1, so resp_sum[31:0] = A-B.
  - In subtract mode resp_sum[32] is the no-borrow flag (1 means A>=B unsigned); req_cin is ignored.
  - A resp_is_sub output (1 bit, reset 0) is registered alongside resp_id.
- Undefined: no req_sub port and no resp_is_sub port; add-only behaviour.

Decomposition:
- Package adder_share_pkg:
  - DATA_W=32, SUM_W=33.
  - Function rr_pick(valid, ptr) returning winner index plus found flag.
- Sub-module rr_arbiter:
  - Combinational winner select from req_valid and rr_ptr.
  - Owns rr_ptr; updates it on accept.
- Top level:
  - Operand mux driven by the winner index.
  - Instantiates the existing 32-bit carry-skip adder (csa32) on the muxed operands.
  - Holds the response register and handshake logic.

Test Plan:
1. Reset, then req_valid=4'b0001, A=0xFFFFFFFF, B=0x1, cin=0 -> next cycle resp_valid=1, resp_sum=0x1_00000000, resp_id=0.
2. All 4 valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0 on consecutive cycles, one result per cycle.
3. Requester 2 valid with resp_ready held 0 for 3 cycles after the first result -> req_ready=0 throughout, resp_sum/resp_id stable; result 2 appears the cycle after resp_ready rises.
4. Requesters 1 and 3 valid with rr_ptr=2 -> 3 is granted first, then 1; cin=1 on A=5, B=7 gives resp_sum=13.
5. rst asserted while resp_valid=1 -> next edge resp_valid=0, rr_ptr=0, and requester 0 wins the next contention.
6. With ADDER_SHARE_ARB_SUB_EN: A=3, B=5, req_sub=1 -> resp_sum[31:0]=0xFFFFFFFE, resp_sum[32]=0, resp_is_sub=1.
